// File: rtl/change_dispenser.sv
// Coin-hopper driver: pays out owed change greedily (quarter, dime, nickel),
// one eject/acknowledge handshake per coin, with jam and empty-hopper faults.
module change_dispenser #(
  parameter int ACK_TIMEOUT = 50,
  parameter int TW          = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       change_req,
  input  logic [4:0] change_amt,
  input  logic       qu_empty,
  input  logic       di_empty,
  input  logic       ni_empty,
  input  logic       coin_ack,
  output logic       eject_qu,
  output logic       eject_di,
  output logic       eject_ni,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [4:0] remaining
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    EJECT,
    WAIT_ACK,
    DONE,
    FAULT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    coin_val;

  // The eject pulse is registered on the SELECT->EJECT edge, so it is high
  // exactly while the FSM sits in EJECT; the chosen coin value is held for
  // the subtraction regardless of later hopper-status changes.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      coin_val  <= '0;
      eject_qu  <= 1'b0;
      eject_di  <= 1'b0;
      eject_ni  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      remaining <= '0;
    end else begin
      eject_qu <= 1'b0;
      eject_di <= 1'b0;
      eject_ni <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (change_req) begin
            remaining <= change_amt;
            busy      <= 1'b1;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (remaining == 5'd0) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (remaining >= 5'd5 && !qu_empty) begin
            coin_val <= 3'd5;
            eject_qu <= 1'b1;
            state    <= EJECT;
          end else if (remaining >= 5'd2 && !di_empty) begin
            coin_val <= 3'd2;
            eject_di <= 1'b1;
            state    <= EJECT;
          end else if (!ni_empty) begin
            coin_val <= 3'd1;
            eject_ni <= 1'b1;
            state    <= EJECT;
          end else begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= FAULT;
          end
        end
        EJECT: begin
          timer <= '0;
          state <= WAIT_ACK;
        end
        // An ack on the expiry cycle still counts as a delivered coin.
        WAIT_ACK: begin
          if (coin_ack) begin
            remaining <= remaining - {2'b00, coin_val};
            state     <= SELECT;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            fault <= 1'b1;
            busy  <= 1'b0;
            state <= FAULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hand-computed coin sequences, remaining
// amounts, done/fault timing and reset behaviour.
module tb_change_dispenser;

  localparam int ACK_TIMEOUT = 50;

  logic       CLK = 1'b0;
  logic       rst;
  logic       change_req;
  logic [4:0] change_amt;
  logic       qu_empty, di_empty, ni_empty;
  logic       coin_ack;
  logic       eject_qu, eject_di, eject_ni;
  logic       busy, done, fault;
  logic [4:0] remaining;

  int total = 0;
  int bad   = 0;

  localparam int QU = 4, DI = 2, NI = 1;

  change_dispenser #(.ACK_TIMEOUT(ACK_TIMEOUT), .TW(8)) dut (
    .CLK(CLK), .rst(rst), .change_req(change_req), .change_amt(change_amt),
    .qu_empty(qu_empty), .di_empty(di_empty), .ni_empty(ni_empty),
    .coin_ack(coin_ack), .eject_qu(eject_qu), .eject_di(eject_di),
    .eject_ni(eject_ni), .busy(busy), .done(done), .fault(fault),
    .remaining(remaining)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int ejectCode();
    return int'({eject_qu, eject_di, eject_ni});
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Pulses change_req; returns in the cycle where the first eject should be high.
  task automatic applyStimulus(input logic [4:0] amt);
    change_amt = amt;
    change_req = 1'b1;
    tick();
    change_req = 1'b0;
    checkOutput("select_busy", int'(busy), 1);
    checkOutput("select_no_eject", ejectCode(), 0);
    tick();
  endtask

  // Called in the eject cycle; acks after 'delay' cycles and returns in the
  // cycle where the next eject (or done) is expected.
  task automatic serveCoin(input string tag, input int exp_code, input int exp_rem,
                           input int delay, input bit poke);
    checkOutput({tag, "_eject"}, ejectCode(), exp_code);
    for (int i = 0; i < delay; i++) begin
      if (poke && i == 0) begin
        change_req = 1'b1;
        change_amt = 5'd20;
      end
      tick();
      change_req = 1'b0;
    end
    checkOutput({tag, "_eject_gone"}, ejectCode(), 0);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    checkOutput({tag, "_rem"}, int'(remaining), exp_rem);
    tick();
  endtask

  task automatic finishDone(input string tag);
    checkOutput({tag, "_done"}, int'(done), 1);
    checkOutput({tag, "_done_rem"}, int'(remaining), 0);
    checkOutput({tag, "_done_noeject"}, ejectCode(), 0);
    tick();
    checkOutput({tag, "_done_low"}, int'(done), 0);
    checkOutput({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  always @(negedge CLK) begin
    if (!rst)
      checkOutput("onehot_eject", int'($countones({eject_qu, eject_di, eject_ni}) <= 1), 1);
  end

  initial begin
    rst = 1'b1; change_req = 1'b0; change_amt = '0; coin_ack = 1'b0;
    qu_empty = 1'b0; di_empty = 1'b0; ni_empty = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_fault", int'(fault), 0);
    checkOutput("reset_rem", int'(remaining), 0);
    checkOutput("reset_eject", ejectCode(), 0);

    $display("[TB] 10 cents, one dime");
    applyStimulus(5'd2);
    serveCoin("t1_di", DI, 0, 3, 1'b0);
    finishDone("t1");

    $display("[TB] 40 cents, quarter dime nickel");
    applyStimulus(5'd8);
    serveCoin("t2_qu", QU, 3, 2, 1'b0);
    serveCoin("t2_di", DI, 1, 1, 1'b0);
    serveCoin("t2_ni", NI, 0, 4, 1'b0);
    finishDone("t2");

    $display("[TB] 35 cents, dimes empty, mid-payout request ignored");
    di_empty = 1'b1;
    applyStimulus(5'd7);
    serveCoin("t3_qu", QU, 2, 2, 1'b1);
    serveCoin("t3_ni1", NI, 1, 2, 1'b0);
    serveCoin("t3_ni2", NI, 0, 2, 1'b0);
    finishDone("t3");
    di_empty = 1'b0;

    $display("[TB] zero amount");
    applyStimulus(5'd0);
    finishDone("t0");

    $display("[TB] nickel owed, nickels empty");
    ni_empty = 1'b1;
    applyStimulus(5'd1);
    checkOutput("t4_fault", int'(fault), 1);
    checkOutput("t4_rem", int'(remaining), 1);
    checkOutput("t4_busy", int'(busy), 0);
    checkOutput("t4_noeject", ejectCode(), 0);
    tick(); tick(); tick();
    checkOutput("t4_fault_sticky", int'(fault), 1);
    ni_empty = 1'b0;
    doReset();
    checkOutput("t4_fault_cleared", int'(fault), 0);
    checkOutput("t4_rem_cleared", int'(remaining), 0);

    $display("[TB] quarter never acknowledged");
    applyStimulus(5'd5);
    checkOutput("t5_eject", ejectCode(), QU);
    for (int i = 0; i < ACK_TIMEOUT; i++) tick();
    checkOutput("t5_no_fault_yet", int'(fault), 0);
    tick();
    checkOutput("t5_fault", int'(fault), 1);
    checkOutput("t5_rem", int'(remaining), 5);
    checkOutput("t5_busy", int'(busy), 0);
    doReset();

    $display("[TB] ack on the expiry cycle");
    applyStimulus(5'd5);
    serveCoin("t5b_qu", QU, 0, ACK_TIMEOUT, 1'b0);
    checkOutput("t5b_no_fault", int'(fault), 0);
    finishDone("t5b");

    $display("[TB] reset during wait for ack");
    applyStimulus(5'd8);
    checkOutput("t6_eject", ejectCode(), QU);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_busy", int'(busy), 0);
    checkOutput("t6_rem", int'(remaining), 0);
    checkOutput("t6_eject_off", ejectCode(), 0);
    checkOutput("t6_fault", int'(fault), 0);
    coin_ack = 1'b1;
    tick();
    coin_ack = 1'b0;
    checkOutput("t6_late_ack_rem", int'(remaining), 0);
    checkOutput("t6_late_ack_busy", int'(busy), 0);
    applyStimulus(5'd1);
    serveCoin("t6_ni", NI, 0, 2, 1'b0);
    finishDone("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
